// File: rtl/ifetch_if.sv
// Instruction-memory req/ack bus between the fetch stage (master) and the
// instruction memory (slave).
interface ifetch_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/ifetch.sv
// RV32I instruction fetch stage: PC register, req/ack fetch FSM and next-PC select.
// Optional macro IFETCH_MISALIGN_TRAP_EN halts on a misaligned next PC instead of masking it.
module ifetch #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  ifetch_if.master        imem,
  output logic [31:0]     instr,
  output logic [6:0]      opcode,
  output logic            instr_valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            stall,
  input  logic            branch,
  input  logic            zero,
  input  logic            jump,
  input  logic            jalr,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_result,
  output logic            misalign
);

`ifdef IFETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {FETCH_REQ, EXEC, HALT} state_e;
`else
  typedef enum logic [1:0] {FETCH_REQ, EXEC} state_e;
`endif

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;
  logic            valid_q;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] next_pc;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    target = pc_q + XLEN'(4);
    if (jalr)
      target = alu_result & ~XLEN'(1);
    else if (jump || (branch && zero))
      target = pc_q + imm;
  end

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic trap_hit;
  logic misalign_q;

  assign next_pc  = target;
  assign trap_hit = |target[1:0];
  assign misalign = misalign_q;
`else
  assign next_pc  = target & ~XLEN'(3);
  assign misalign = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH_REQ;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        FETCH_REQ: begin
          if (imem.imem_ack) begin
            instr_q <= imem.imem_rdata;
            valid_q <= 1'b1;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (!stall) begin
            pc_q    <= next_pc;
            valid_q <= 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
            if (trap_hit) begin
              state_q    <= HALT;
              misalign_q <= 1'b1;
            end else begin
              state_q    <= FETCH_REQ;
            end
`else
            state_q <= FETCH_REQ;
`endif
          end
        end
        default: ;  // HALT is sticky until reset
      endcase
    end
  end

  // NOTE: reset state is FETCH_REQ, so the request is gated by rst_n to drop the instant reset asserts.
  assign imem.imem_req  = rst_n && (state_q == FETCH_REQ);
  assign imem.imem_addr = pc_q;

  assign instr       = instr_q;
  assign opcode      = instr_q[6:0];
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + XLEN'(4);

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: phase-level scoreboard checked every falling edge,
// plus hand-computed literal fetch addresses after each instruction.
module tb_ifetch;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic            instr_valid;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            stall, branch, zero, jump, jalr;
  logic [XLEN-1:0] imm, alu_result;
  logic            misalign;

  ifetch_if #(.XLEN(XLEN)) imem_bus ();

  ifetch #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem       (imem_bus),
    .instr      (instr),
    .opcode     (opcode),
    .instr_valid(instr_valid),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .stall      (stall),
    .branch     (branch),
    .zero       (zero),
    .jump       (jump),
    .jalr       (jalr),
    .imm        (imm),
    .alu_result (alu_result),
    .misalign   (misalign)
  );

  always #5 clk = ~clk;

  typedef enum {PH_RST, PH_FETCH, PH_EXEC, PH_HALT} phase_e;
  phase_e      ph = PH_RST;
  logic [31:0] exp_pc    = 32'h0;
  logic [31:0] exp_instr = 32'h0000_0013;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural next-PC rule: jalr > jump > taken branch > sequential.
  function automatic logic [31:0] ref_target(input logic [31:0] cur, input logic br, input logic z,
                                             input logic j, input logic jr,
                                             input logic [31:0] off, input logic [31:0] alu);
    if (jr)               return alu - {31'b0, alu[0]};
    if (j || (br && z))   return cur + off;
    return cur + 32'd4;
  endfunction

  always @(negedge clk) begin
    case (ph)
      PH_RST: begin
        check("rst_req",   {31'b0, imem_bus.imem_req}, 32'd0);
        check("rst_valid", {31'b0, instr_valid},       32'd0);
        check("rst_pc",    pc,                         32'h0);
        check("rst_instr", instr,                      32'h0000_0013);
      end
      PH_FETCH: begin
        check("fetch_req",   {31'b0, imem_bus.imem_req}, 32'd1);
        check("fetch_addr",  imem_bus.imem_addr,         exp_pc);
        check("fetch_valid", {31'b0, instr_valid},       32'd0);
        check("fetch_pc",    pc,                         exp_pc);
      end
      PH_EXEC: begin
        check("exec_req",    {31'b0, imem_bus.imem_req}, 32'd0);
        check("exec_valid",  {31'b0, instr_valid},       32'd1);
        check("exec_instr",  instr,                      exp_instr);
        check("exec_opcode", {25'b0, opcode},            {25'b0, exp_instr[6:0]});
        check("exec_pc",     pc,                         exp_pc);
        check("exec_pc4",    pc_plus4,                   exp_pc + 32'd4);
      end
      PH_HALT: begin
        check("halt_req",   {31'b0, imem_bus.imem_req}, 32'd0);
        check("halt_valid", {31'b0, instr_valid},       32'd0);
        check("halt_mis",   {31'b0, misalign},          32'd1);
        check("halt_pc",    pc,                         exp_pc);
      end
      default: ;
    endcase
    if (ph != PH_HALT)
      check("misalign_low", {31'b0, misalign}, 32'd0);
  end

  // Entered just after a rising edge with the DUT fetching exp_pc.
  task automatic run_instr(input logic [31:0] word, input int wt, input int st,
                           input logic br, input logic z, input logic j, input logic jr,
                           input logic [31:0] off, input logic [31:0] alu, input logic [31:0] p4_pin);
    logic [31:0] t;
    for (int i = 0; i < wt; i++) begin
      imem_bus.imem_ack   = 1'b0;
      imem_bus.imem_rdata = $urandom;
      @(posedge clk); #1;
    end
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = word;
    @(posedge clk); #1;
    ph        = PH_EXEC;
    exp_instr = word;
    imem_bus.imem_rdata = ~word;  // stray ack during execute must be ignored
    branch = br; zero = z; jump = j; jalr = jr; imm = off; alu_result = alu;
    if (p4_pin != 32'h0) check("pc_plus4_pin", pc_plus4, p4_pin);
    stall = 1'b1;
    repeat (st) begin @(posedge clk); #1; end
    stall = 1'b0;
    @(posedge clk); #1;
    imem_bus.imem_ack = 1'b0;
    branch = 0; zero = 0; jump = 0; jalr = 0; imm = '0; alu_result = '0;
    t = ref_target(exp_pc, br, z, j, jr, off, alu);
`ifdef IFETCH_MISALIGN_TRAP_EN
    if (t[1:0] != 2'b00) begin
      ph     = PH_HALT;
      exp_pc = t;
    end else begin
      ph     = PH_FETCH;
      exp_pc = t;
    end
`else
    ph     = PH_FETCH;
    exp_pc = {t[31:2], 2'b00};
`endif
  endtask

  localparam logic [31:0] ADDI = 32'h0000_0093;
  localparam logic [31:0] JAL  = 32'h0000_006F;
  localparam logic [31:0] BEQ  = 32'h0000_0063;
  localparam logic [31:0] JALR = 32'h0000_8067;

  initial begin
    rst_n = 1'b0;
    stall = 0; branch = 0; zero = 0; jump = 0; jalr = 0; imm = '0; alu_result = '0;
    imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = '0;
    repeat (2) begin @(posedge clk); #1; end
    check("reset_instr_nop", instr, 32'h0000_0013);
    check("reset_opcode",    {25'b0, opcode}, 32'h13);

    rst_n = 1'b1; ph = PH_FETCH; exp_pc = 32'h0;
    #1;
    check("first_req",  {31'b0, imem_bus.imem_req}, 32'd1);
    check("first_addr", imem_bus.imem_addr, 32'h0);

    run_instr(ADDI, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    check("seq_to_4", imem_bus.imem_addr, 32'h4);
    run_instr(32'h0000_0033, 3, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    check("held_instr_33",  instr, 32'h0000_0033);
    check("held_opcode_33", {25'b0, opcode}, 32'h33);
    check("seq_to_8", imem_bus.imem_addr, 32'h8);
    run_instr(JAL, 0, 0, 0, 0, 1, 0, 32'h8, 32'h0, 32'h0);
    check("jal_to_10", imem_bus.imem_addr, 32'h10);
    run_instr(BEQ, 1, 0, 1, 1, 0, 0, 32'hFFFF_FFF8, 32'h0, 32'h0);
    check("br_taken_to_08", imem_bus.imem_addr, 32'h08);
    run_instr(JAL, 0, 0, 0, 0, 1, 0, 32'h8, 32'h0, 32'h0);
    run_instr(BEQ, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFF8, 32'h0, 32'h0);
    check("br_not_taken_to_14", imem_bus.imem_addr, 32'h14);
    run_instr(JAL, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFC, 32'h0, 32'h0);
    run_instr(JAL, 2, 0, 0, 0, 1, 0, 32'h100, 32'h0, 32'h0);
    check("jal_to_110", imem_bus.imem_addr, 32'h110);
    run_instr(JALR, 0, 0, 0, 0, 0, 1, 32'h0, 32'h21, 32'h0);
    check("jalr_to_20", imem_bus.imem_addr, 32'h20);
    run_instr(JALR, 0, 0, 0, 0, 1, 1, 32'h40, 32'h101, 32'h24);
    check("jalr_wins_to_100", imem_bus.imem_addr, 32'h100);
    run_instr(32'h0010_0093, 1, 4, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    check("stall_then_104", imem_bus.imem_addr, 32'h104);
    run_instr(JAL, 0, 0, 0, 0, 1, 0, 32'hFFFF_FEF8, 32'h0, 32'h0);
    check("jal_to_top", imem_bus.imem_addr, 32'hFFFF_FFFC);
    run_instr(ADDI, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    check("wrap_to_0", imem_bus.imem_addr, 32'h0);
    run_instr(ADDI, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);

    // Reset pulse while waiting for an ack at pc=4.
    imem_bus.imem_ack = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0; ph = PH_RST;
    #1;
    check("midwait_req_drop", {31'b0, imem_bus.imem_req}, 32'd0);
    check("midwait_pc_reset", pc, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1; ph = PH_FETCH; exp_pc = 32'h0;

    run_instr(JAL, 0, 0, 0, 0, 1, 0, 32'h102, 32'h0, 32'h0);
`ifdef IFETCH_MISALIGN_TRAP_EN
    repeat (3) begin @(posedge clk); #1; end
    check("trap_misalign", {31'b0, misalign}, 32'd1);
    check("trap_no_req",   {31'b0, imem_bus.imem_req}, 32'd0);
    check("trap_pc",       pc, 32'h102);
`else
    check("mask_to_100",  imem_bus.imem_addr, 32'h100);
    check("mask_no_flag", {31'b0, misalign}, 32'd0);
    @(posedge clk); #1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
